mod_clkgen_multiphase: RTL and testbench
========================================

MOD_CLKGEN_MULTIPHASE -- requirements
Module: mod_clkgen_multiphase

Interface
REQ-001 SHALL have parameter DIV_W, default 16: width of half-period count in CLK_IN cycles.
REQ-002 SHALL have parameter DEAD_W, default 8: width of dead-time count.
REQ-003 SHALL have parameter H_INIT, default 50: half-period active after reset.
REQ-004 SHALL have parameter DT_INIT, default 4: dead time active after reset.
REQ-005 SHALL have parameter PH_INIT, default 0: MODL phase offset active after reset.
REQ-006 SHALL have port CLK_IN  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port RESET_N  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port ENABLE  input  1  level; run the generator while high.
REQ-009 SHALL have port LOAD  input  1  one-cycle strobe; capture the configuration inputs.
REQ-010 SHALL have port HALF_PERIOD  input  DIV_W  half-period H, in CLK_IN cycles.
REQ-011 SHALL have port DEAD_TIME  input  DEAD_W  non-overlap gap DT, in CLK_IN cycles.
REQ-012 SHALL have port PHASE_OFS  input  DIV_W+1  MODL delay PH relative to MOD, in CLK_IN cycles.
REQ-013 SHALL have port CLK_OUT_MOD  output  1  primary phase, registered.
REQ-014 SHALL have port CLK_OUT_MODN  output  1  complementary non-overlapping phase, registered.
REQ-015 SHALL have port CLK_OUT_MODL  output  1  50% duty clock delayed by PH, registered.
REQ-016 SHALL have port PERIOD_START  output  1  one-cycle pulse when the period counter is 0.
REQ-017 SHALL have port CFG_PENDING  output  1  shadow configuration waiting for a period boundary.
REQ-018 SHALL have port CFG_ERR  output  1  sticky flag: last LOAD was rejected.

Function
REQ-019 SHALL keep a period counter cnt, range 0..P-1, where P = 2*H is computed at DIV_W+1 bits; cnt wraps P-1 -> 0.
REQ-020 SHALL, in RUN, drive MOD=1 iff cnt < H-DT.
REQ-021 SHALL, in RUN, drive MODN=1 iff H <= cnt < P-DT, so MOD and MODN are never high together.
REQ-022 SHALL, in RUN, drive MODL=1 iff ((cnt + P - PH) mod P) < H.
REQ-023 SHALL register all outputs so that each output reflects the cnt value held after the same clock edge.
REQ-024 SHALL implement states IDLE, RUN and STOP.
REQ-025 SHALL, in IDLE with ENABLE sampled high, enter RUN with cnt=0 on that same edge, so MOD and PERIOD_START are high in the first cycle.
REQ-026 SHALL, in RUN with ENABLE sampled low, enter STOP and continue the current period.
REQ-027 SHALL, in STOP at cnt=P-1, enter IDLE; if ENABLE is high again at that edge, SHALL instead enter RUN with cnt=0.
REQ-028 SHALL hold all clock outputs and PERIOD_START at 0 in IDLE.
REQ-029 SHALL, on LOAD, capture HALF_PERIOD, DEAD_TIME and PHASE_OFS into a shadow register and set CFG_PENDING.
REQ-030 SHALL treat a configuration as valid iff H >= 1, DT < H and PH < 2*H.
REQ-031 SHALL, on LOAD of an invalid configuration, set CFG_ERR, discard the shadow and leave CFG_PENDING unchanged.
REQ-032 SHALL clear CFG_ERR on any valid LOAD.
REQ-033 SHALL apply a pending shadow at the edge where cnt wraps P-1 -> 0; if in IDLE, SHALL apply it on the next edge. SHALL clear CFG_PENDING when the shadow is applied.
REQ-034 SHALL, when LOAD coincides with a wrap edge, capture the new values into the shadow and apply them at the following wrap; any older pending shadow SHALL be applied at the coincident wrap.
REQ-035 SHALL let a second LOAD while pending overwrite the shadow; the last valid LOAD wins.
REQ-036 SHALL never change the period mid-cycle: no output pulse shorter than its configured width except on reset.

Reset
REQ-037 SHALL, while RESET_N is low, asynchronously force all outputs to 0, the state to IDLE, cnt to 0, and the active configuration to H_INIT/DT_INIT/PH_INIT.
REQ-038 SHALL, while RESET_N is low, clear the shadow register, CFG_PENDING and CFG_ERR.
REQ-039 SHALL resume operation on the first CLK_IN edge after RESET_N deasserts.

Verification
REQ-040 SHALL cover: load H=4, DT=1, PH=2, then ENABLE=1 -> P=8; MOD high at cnt 0-2; MODN high at cnt 4-6; MODL high at cnt 2-5; PERIOD_START every 8 cycles.
REQ-041 SHALL cover: running at H=4, LOAD H=6 at cnt=3 -> CFG_PENDING=1 until the wrap, then P=12 starting at cnt=0; no truncated pulse.
REQ-042 SHALL cover: LOAD H=4, DT=4 -> CFG_ERR=1, active configuration unchanged; a subsequent valid LOAD clears CFG_ERR.
REQ-043 SHALL cover: ENABLE dropped at cnt=2 -> the period completes through cnt=7, then all outputs are 0 and the state is IDLE.
REQ-044 SHALL cover: RESET_N asserted mid-period -> outputs are 0 immediately without a clock edge; after release, H=50 and DT=4 are active.
REQ-045 SHALL cover: random configurations over 10k cycles -> MOD and MODN are never high simultaneously.

Source files
------------

// File: rtl/mod_clkgen_multiphase.sv
// rtl/mod_clkgen_multiphase.sv - multiphase clock generator (MOD/MODN/MODL) with shadowed config
// Outputs are computed from the post-edge counter and config, then registered.
module mod_clkgen_multiphase #(
    parameter int DIV_W   = 16,
    parameter int DEAD_W  = 8,
    parameter int H_INIT  = 50,
    parameter int DT_INIT = 4,
    parameter int PH_INIT = 0
) (
    input  logic              CLK_IN,
    input  logic              RESET_N,
    input  logic              ENABLE,
    input  logic              LOAD,
    input  logic [DIV_W-1:0]  HALF_PERIOD,
    input  logic [DEAD_W-1:0] DEAD_TIME,
    input  logic [DIV_W:0]    PHASE_OFS,
    output logic              CLK_OUT_MOD,
    output logic              CLK_OUT_MODN,
    output logic              CLK_OUT_MODL,
    output logic              PERIOD_START,
    output logic              CFG_PENDING,
    output logic              CFG_ERR
);

    localparam int CW = ((DIV_W > DEAD_W) ? DIV_W : DEAD_W) + 2;

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t            state_q, state_d;
    logic [DIV_W:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]  h_q, h_d, sh_h_q, sh_h_d;
    logic [DEAD_W-1:0] dt_q, dt_d, sh_dt_q, sh_dt_d;
    logic [DIV_W:0]    ph_q, ph_d, sh_ph_q, sh_ph_d;
    logic              pend_q, pend_d, err_q, err_d;
    logic              mod_q, mod_d, modn_q, modn_d, modl_q, modl_d, ps_q, ps_d;

    logic [CW-1:0]     p_cur, p_new, c, t;
    logic              wrap, ld_ok, apply, run;

    always_comb begin
        p_cur = CW'(h_q) << 1;
        wrap  = (state_q != IDLE) && (CW'(cnt_q) == p_cur - CW'(1));
        ld_ok = LOAD && (HALF_PERIOD != '0)
                && (CW'(DEAD_TIME) < CW'(HALF_PERIOD))
                && (CW'(PHASE_OFS) < (CW'(HALF_PERIOD) << 1));
        // A pending shadow only takes effect at a period boundary (or immediately when idle).
        apply = pend_q && (wrap || (state_q == IDLE));

        state_d = state_q;
        cnt_d   = cnt_q + (DIV_W+1)'(1);
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ENABLE) state_d = RUN;
            end
            RUN: begin
                if (wrap) begin
                    cnt_d = '0;
                    if (!ENABLE) state_d = IDLE;
                end else if (!ENABLE) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (wrap) begin
                    cnt_d   = '0;
                    state_d = ENABLE ? RUN : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        h_d  = apply ? sh_h_q  : h_q;
        dt_d = apply ? sh_dt_q : dt_q;
        ph_d = apply ? sh_ph_q : ph_q;

        sh_h_d  = ld_ok ? HALF_PERIOD : sh_h_q;
        sh_dt_d = ld_ok ? DEAD_TIME   : sh_dt_q;
        sh_ph_d = ld_ok ? PHASE_OFS   : sh_ph_q;
        pend_d  = ld_ok || (pend_q && !apply);
        err_d   = LOAD ? !ld_ok : err_q;

        p_new = CW'(h_d) << 1;
        c     = CW'(cnt_d);
        t     = c + p_new - CW'(ph_d);
        if (t >= p_new) t = t - p_new;
        run    = (state_d != IDLE);
        mod_d  = run && (c < CW'(h_d) - CW'(dt_d));
        modn_d = run && (c >= CW'(h_d)) && (c < p_new - CW'(dt_d));
        modl_d = run && (t < CW'(h_d));
        ps_d   = run && (cnt_d == '0);
    end

    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            h_q     <= DIV_W'(H_INIT);
            dt_q    <= DEAD_W'(DT_INIT);
            ph_q    <= (DIV_W+1)'(PH_INIT);
            sh_h_q  <= '0;
            sh_dt_q <= '0;
            sh_ph_q <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            mod_q   <= 1'b0;
            modn_q  <= 1'b0;
            modl_q  <= 1'b0;
            ps_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            dt_q    <= dt_d;
            ph_q    <= ph_d;
            sh_h_q  <= sh_h_d;
            sh_dt_q <= sh_dt_d;
            sh_ph_q <= sh_ph_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            mod_q   <= mod_d;
            modn_q  <= modn_d;
            modl_q  <= modl_d;
            ps_q    <= ps_d;
        end
    end

    assign CLK_OUT_MOD  = mod_q;
    assign CLK_OUT_MODN = modn_q;
    assign CLK_OUT_MODL = modl_q;
    assign PERIOD_START = ps_q;
    assign CFG_PENDING  = pend_q;
    assign CFG_ERR      = err_q;

endmodule

// File: tb/tb_mod_clkgen_multiphase.sv
// tb/tb_mod_clkgen_multiphase.sv - self-checking bench for mod_clkgen_multiphase
module tb_mod_clkgen_multiphase;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        ld = 1'b0;
    logic [15:0] hp = '0;
    logic [7:0]  dtm = '0;
    logic [16:0] pho = '0;
    logic        mod, modn, modl, ps, pend, err;
    logic [5:0]  obs;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mod_clkgen_multiphase dut (
        .CLK_IN       (clk),
        .RESET_N      (rst_n),
        .ENABLE       (en),
        .LOAD         (ld),
        .HALF_PERIOD  (hp),
        .DEAD_TIME    (dtm),
        .PHASE_OFS    (pho),
        .CLK_OUT_MOD  (mod),
        .CLK_OUT_MODN (modn),
        .CLK_OUT_MODL (modl),
        .PERIOD_START (ps),
        .CFG_PENDING  (pend),
        .CFG_ERR      (err)
    );

    // obs = {MOD, MODN, MODL, PERIOD_START, CFG_PENDING, CFG_ERR}
    assign obs = {mod, modn, modl, ps, pend, err};

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] h;
        logic [7:0]  dt;
        logic [16:0] ph;
        logic [5:0]  exp;
    } vec_t;

    vec_t vt[12];
    logic [5:0] exp_stop[7];

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 'h%0h required 'h%0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_ps(input int bound, output int n, output int nmod,
                             output int nmodn, output int nmodl);
        n = 0; nmod = 0; nmodn = 0; nmodl = 0;
        while (n < bound) begin
            step();
            n++;
            if (ps) break;
            nmod  += int'(mod);
            nmodn += int'(modn);
            nmodl += int'(modl);
        end
    endtask

    int n, nm, nmn, nml, viol;

    initial begin
        vt[0]  = '{1'b0, 1'b0, 16'd0, 8'd0, 17'd0, 6'b000000};
        vt[1]  = '{1'b0, 1'b1, 16'd4, 8'd1, 17'd2, 6'b000010};
        vt[2]  = '{1'b0, 1'b0, 16'd0, 8'd0, 17'd0, 6'b000000};
        vt[3]  = '{1'b1, 1'b0, 16'd0, 8'd0, 17'd0, 6'b100100};
        vt[4]  = '{1'b1, 1'b0, 16'd0, 8'd0, 17'd0, 6'b100000};
        vt[5]  = '{1'b1, 1'b0, 16'd0, 8'd0, 17'd0, 6'b101000};
        vt[6]  = '{1'b1, 1'b0, 16'd0, 8'd0, 17'd0, 6'b001000};
        vt[7]  = '{1'b1, 1'b0, 16'd0, 8'd0, 17'd0, 6'b011000};
        vt[8]  = '{1'b1, 1'b0, 16'd0, 8'd0, 17'd0, 6'b011000};
        vt[9]  = '{1'b1, 1'b0, 16'd0, 8'd0, 17'd0, 6'b010000};
        vt[10] = '{1'b1, 1'b0, 16'd0, 8'd0, 17'd0, 6'b000000};
        vt[11] = '{1'b1, 1'b0, 16'd0, 8'd0, 17'd0, 6'b100100};
        exp_stop[0] = 6'b001000;
        exp_stop[1] = 6'b011000;
        exp_stop[2] = 6'b011000;
        exp_stop[3] = 6'b010000;
        exp_stop[4] = 6'b000000;
        exp_stop[5] = 6'b000000;
        exp_stop[6] = 6'b000000;

        #1;
        check("reset_state", int'(obs), 0);
        step();
        step();
        rst_n = 1'b1;

        // Basic H=4 DT=1 PH=2 waveform, one full period plus the next start.
        for (int i = 0; i < 12; i++) begin
            en = vt[i].en; ld = vt[i].ld; hp = vt[i].h; dtm = vt[i].dt; pho = vt[i].ph;
            step();
            check($sformatf("vec%0d", i), int'(obs), int'(vt[i].exp));
        end
        ld = 1'b0;

        // Reload H=6 at cnt=3: pending until wrap, then a full 12-cycle period.
        step(); step(); step();
        ld = 1'b1; hp = 16'd6; dtm = 8'd1; pho = 17'd2;
        step();
        ld = 1'b0;
        check("reload_cnt4", int'(obs), 'b011010);
        step(); step(); step();
        check("reload_cnt7_old_cfg", int'(obs), 'b000010);
        step();
        check("reload_wrap", int'(obs), 'b100100);
        run_to_ps(30, n, nm, nmn, nml);
        check("reload_period", n, 12);
        check("reload_mod_width", nm, 4);
        check("reload_modn_width", nmn, 5);
        check("reload_modl_width", nml, 6);

        // Invalid LOAD (DT == H): error flagged, config and pending untouched.
        ld = 1'b1; hp = 16'd4; dtm = 8'd4; pho = 17'd0;
        step();
        ld = 1'b0;
        check("bad_load", int'(obs), 'b100001);
        run_to_ps(30, n, nm, nmn, nml);
        check("bad_load_period_kept", n, 11);
        check("err_sticky", int'(obs), 'b100101);
        ld = 1'b1; hp = 16'd4; dtm = 8'd1; pho = 17'd2;
        step();
        ld = 1'b0;
        check("good_load_clears_err", int'(obs), 'b100010);
        run_to_ps(30, n, nm, nmn, nml);
        check("good_load_wait", n, 11);
        check("good_load_applied", int'(obs), 'b100100);

        // ENABLE dropped at cnt=2: period finishes through cnt=7, then IDLE.
        step(); step();
        check("pre_stop_cnt2", int'(obs), 'b101000);
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check($sformatf("stop%0d", i), int'(obs), int'(exp_stop[i]));
        end

        // Asynchronous reset mid-period clears everything without a clock edge.
        en = 1'b1;
        step();
        check("restart", int'(obs), 'b100100);
        ld = 1'b1; hp = 16'd5; dtm = 8'd1; pho = 17'd0;
        step();
        ld = 1'b0;
        check("pre_reset", int'(obs), 'b100010);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", int'(obs), 0);
        step();
        check("reset_held", int'(obs), 0);
        rst_n = 1'b1;
        step();
        check("post_reset_start", int'(obs), 'b101100);
        run_to_ps(200, n, nm, nmn, nml);
        check("default_period", n, 100);
        check("default_mod_width", nm, 45);
        check("default_modn_width", nmn, 46);
        check("default_modl_width", nml, 49);

        // Random configurations: MOD and MODN must never overlap.
        viol = 0;
        for (int i = 0; i < 10000; i++) begin
            en  = ($urandom_range(0, 19) != 0);
            ld  = ($urandom_range(0, 15) == 0);
            hp  = 16'($urandom_range(0, 12));
            dtm = 8'($urandom_range(0, 12));
            pho = 17'($urandom_range(0, 25));
            step();
            if (mod && modn) viol++;
        end
        ld = 1'b0;
        check("no_overlap", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
